// File: rtl/mux_nto1_pkg.sv
// Shared definitions for the N:1 round-robin mux and its arbiter.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package mux_nto1_pkg;

    // Selection mode encodings
    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Width of each per-channel transfer counter
    localparam int STAT_W = 8;

    // Largest supported channel count; the helper works on vectors padded to this size
    localparam int MAX_CH    = 16;
    localparam int MAX_SEL_W = 4;

    typedef struct packed {
        logic                 vld;
        logic [MAX_SEL_W-1:0] idx;
    } rr_pick_t;

    // Round-robin pick: scan ptr+1, ptr+2, ... modulo n_ch and return the first
    // requesting channel. The loop walks from the farthest offset down to the
    // nearest so that the nearest requester is the one left in the result.
    function automatic rr_pick_t rr_pick(input logic [MAX_CH-1:0]    valid,
                                         input logic [MAX_SEL_W-1:0] ptr,
                                         input int                   n_ch);
        rr_pick_t r;
        int       c;
        r = '0;
        for (int i = MAX_CH; i >= 1; i--) begin
            if (i <= n_ch) begin
                c = (int'(ptr) + i) % n_ch;
                if (valid[c]) begin
                    r.vld = 1'b1;
                    r.idx = MAX_SEL_W'(c);
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mux_nto1_rr_arbiter.sv
// Round-robin arbiter: combinational pick among requesters plus the priority pointer.
// Latency: grant is combinational; pointer moves on the clock edge where adv_i is high.
// Backpressure: caller qualifies adv_i with its own load condition; no grant is held here.
module rr_arbiter
    import mux_nto1_pkg::*;
#(
    parameter  int N_CH  = 4,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_CH-1:0]  req_i,
    input  logic             adv_i,
    output logic             gnt_vld_o,
    output logic [SEL_W-1:0] gnt_idx_o
);

    logic [SEL_W-1:0]     ptr_q;
    logic [SEL_W-1:0]     ptr_d;
    logic [MAX_CH-1:0]    req_ext;
    logic [MAX_SEL_W-1:0] ptr_ext;
    logic [SEL_W:0]       pick;

    // Narrow the package helper's result to this instance's index width
    function automatic logic [SEL_W:0] pick_narrow(input logic [MAX_CH-1:0]    v,
                                                   input logic [MAX_SEL_W-1:0] p);
        rr_pick_t r;
        r = rr_pick(v, p, N_CH);
        return {r.vld, r.idx[SEL_W-1:0]};
    endfunction

    // Pad request vector and pointer up to the helper's fixed width
    always_comb begin
        req_ext              = '0;
        req_ext[N_CH-1:0]    = req_i;
        ptr_ext              = '0;
        ptr_ext[SEL_W-1:0]   = ptr_q;
    end

    // Combinational pick starting just after the last granted channel
    always_comb begin
        pick = pick_narrow(req_ext, ptr_ext);
    end

    assign gnt_vld_o = pick[SEL_W];
    assign gnt_idx_o = pick[SEL_W-1:0];

    // Pointer follows the granted channel only when the grant is actually used
    always_comb begin
        ptr_d = ptr_q;
        if (adv_i && gnt_vld_o) begin
            ptr_d = gnt_idx_o;
        end
    end

    // Pointer register; resets to the last channel so channel 0 is scanned first
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= SEL_W'(N_CH - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/mux_nto1_rr.sv
// N:1 valid/ready mux with fixed-select or round-robin arbitration and a registered output.
// Latency: 1 cycle from input transfer to valid_out; one word per cycle while ready_in=1.
// Backpressure: ready_in=0 with a held word freezes the output register and drops all ready_out.
// Optional build macro MUX_NTO1_STATS_EN adds per-channel transfer counters and a stall flag.
module mux_nto1_rr
    import mux_nto1_pkg::*;
#(
    parameter  int DATA_W = 2,
    parameter  int N_CH   = 4,
    localparam int SEL_W  = $clog2(N_CH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     mode,
    input  logic [SEL_W-1:0]         selector,
    input  logic [N_CH-1:0]          valid_in,
    input  logic [N_CH*DATA_W-1:0]   data_in,
    output logic [N_CH-1:0]          ready_out,
    output logic                     valid_out,
    output logic [DATA_W-1:0]        data_out,
    output logic [SEL_W-1:0]         sel_out,
    input  logic                     ready_in
`ifdef MUX_NTO1_STATS_EN
    ,
    output logic [N_CH*STAT_W-1:0]   xfer_cnt,
    output logic                     stall
`endif
);

    // Selector space may exceed N_CH when N_CH is not a power of two
    localparam int N_PAD = 1 << SEL_W;

    logic              valid_q;
    logic              valid_d;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_d;
    logic [SEL_W-1:0]  sel_q;
    logic [SEL_W-1:0]  sel_d;

    logic              load;
    logic [N_PAD-1:0]  valid_pad;
    logic              fix_vld;
    logic              arb_vld;
    logic [SEL_W-1:0]  arb_idx;
    logic              arb_adv;
    logic              gnt_vld;
    logic [SEL_W-1:0]  gnt_idx;

    // Output register may accept a new word when empty or being drained this cycle
    assign load = !valid_q || ready_in;

    // Fixed-mode grant: padding bits are zero, so an out-of-range selector never grants
    always_comb begin
        valid_pad           = '0;
        valid_pad[N_CH-1:0] = valid_in;
        fix_vld             = valid_pad[selector];
    end

    assign arb_adv = load && (mode == MODE_RR);

    rr_arbiter #(
        .N_CH (N_CH)
    ) u_arb (
        .clk       (clk),
        .reset     (reset),
        .req_i     (valid_in),
        .adv_i     (arb_adv),
        .gnt_vld_o (arb_vld),
        .gnt_idx_o (arb_idx)
    );

    // Pick the grant source for the current mode
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        if (mode == MODE_RR) begin
            gnt_vld = arb_vld;
            gnt_idx = arb_idx;
        end else begin
            gnt_vld = fix_vld;
            gnt_idx = selector;
        end
    end

    // One-hot pop to the granted channel; forced low while reset is asserted
    always_comb begin
        ready_out = '0;
        if (!reset && load && gnt_vld) begin
            ready_out[gnt_idx] = 1'b1;
        end
    end

    // Output register next state: load granted word, clear on empty load, else hold
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        sel_d   = sel_q;
        if (load) begin
            if (gnt_vld) begin
                valid_d = 1'b1;
                data_d  = data_in[gnt_idx*DATA_W +: DATA_W];
                sel_d   = gnt_idx;
            end else begin
                valid_d = 1'b0;
                data_d  = '0;
            end
        end
    end

    // Output register; reset discards any held word
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            sel_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
        end
    end

    assign valid_out = valid_q;
    assign data_out  = data_q;
    assign sel_out   = sel_q;

`ifdef MUX_NTO1_STATS_EN
    // Held word that downstream is refusing this cycle
    assign stall = valid_q && !ready_in;

    for (genvar k = 0; k < N_CH; k++) begin : g_stat
        logic [STAT_W-1:0] cnt_q;
        logic [STAT_W-1:0] cnt_d;

        // Count input transfers from channel k, sticking at all-ones
        always_comb begin
            cnt_d = cnt_q;
            if (ready_out[k] && valid_in[k] && (cnt_q != {STAT_W{1'b1}})) begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        // Counter register for channel k
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign xfer_cnt[k*STAT_W +: STAT_W] = cnt_q;
    end
`endif

endmodule

// File: tb/tb_mux_nto1_rr.sv
// Directed bench for mux_nto1_rr (DATA_W=2, N_CH=4): vector table plus reset/stats sequences.
// Latency: checks ready_out combinationally and registered outputs one edge later.
// Backpressure: exercised by holding ready_in low for three cycles mid-stream.
module tb_mux_nto1_rr;

    logic       clk;
    logic       reset;
    logic       mode;
    logic [1:0] selector;
    logic [3:0] valid_in;
    logic [7:0] data_in;
    logic [3:0] ready_out;
    logic       valid_out;
    logic [1:0] data_out;
    logic [1:0] sel_out;
    logic       ready_in;
`ifdef MUX_NTO1_STATS_EN
    logic [31:0] xfer_cnt;
    logic        stall;
`endif

    int n_checks;
    int n_pass;

    mux_nto1_rr #(
        .DATA_W (2),
        .N_CH   (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .mode      (mode),
        .selector  (selector),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .ready_out (ready_out),
        .valid_out (valid_out),
        .data_out  (data_out),
        .sel_out   (sel_out),
        .ready_in  (ready_in)
`ifdef MUX_NTO1_STATS_EN
        ,
        .xfer_cnt  (xfer_cnt),
        .stall     (stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       mode;
        logic [1:0] sel;
        logic [3:0] vin;
        logic [7:0] din;
        logic       rdy;
        logic [3:0] exp_rdy;
        logic       exp_vout;
        logic [1:0] exp_dat;
        logic [1:0] exp_sel;
    } vec_t;

    vec_t vecs [21];

    // ch0=3, ch1=2, ch2=1, ch3=0 so data never equals channel id
    localparam logic [7:0] D_RR = 8'b00_01_10_11;

    initial begin
        n_checks = 0;
        n_pass   = 0;

        //                mode sel vin      din            rdy  exp_rdy  vout dat    sel
        vecs[0]  = '{1'b0, 2'd2, 4'b0100, 8'b00_11_10_01, 1'b1, 4'b0100, 1'b1, 2'b11, 2'd2};
        vecs[1]  = '{1'b0, 2'd1, 4'b1001, 8'b00_11_10_01, 1'b1, 4'b0000, 1'b0, 2'b00, 2'd2};
        vecs[2]  = '{1'b0, 2'd1, 4'b1001, 8'b00_11_10_01, 1'b1, 4'b0000, 1'b0, 2'b00, 2'd2};
        vecs[3]  = '{1'b0, 2'd3, 4'b1001, 8'b10_00_00_01, 1'b1, 4'b1000, 1'b1, 2'b10, 2'd3};
        vecs[4]  = '{1'b1, 2'd0, 4'b1111, D_RR,           1'b1, 4'b0001, 1'b1, 2'd3,  2'd0};
        vecs[5]  = '{1'b1, 2'd0, 4'b1111, D_RR,           1'b1, 4'b0010, 1'b1, 2'd2,  2'd1};
        vecs[6]  = '{1'b1, 2'd0, 4'b1111, D_RR,           1'b1, 4'b0100, 1'b1, 2'd1,  2'd2};
        vecs[7]  = '{1'b1, 2'd0, 4'b1111, D_RR,           1'b1, 4'b1000, 1'b1, 2'd0,  2'd3};
        vecs[8]  = '{1'b1, 2'd0, 4'b1111, D_RR,           1'b1, 4'b0001, 1'b1, 2'd3,  2'd0};
        vecs[9]  = '{1'b1, 2'd0, 4'b1111, D_RR,           1'b1, 4'b0010, 1'b1, 2'd2,  2'd1};
        vecs[10] = '{1'b1, 2'd0, 4'b1001, D_RR,           1'b1, 4'b1000, 1'b1, 2'd0,  2'd3};
        vecs[11] = '{1'b1, 2'd0, 4'b0110, D_RR,           1'b1, 4'b0010, 1'b1, 2'd2,  2'd1};
        vecs[12] = '{1'b1, 2'd0, 4'b0000, D_RR,           1'b1, 4'b0000, 1'b0, 2'd0,  2'd1};
        vecs[13] = '{1'b1, 2'd0, 4'b0001, D_RR,           1'b1, 4'b0001, 1'b1, 2'd3,  2'd0};
        vecs[14] = '{1'b1, 2'd0, 4'b1111, D_RR,           1'b0, 4'b0000, 1'b1, 2'd3,  2'd0};
        vecs[15] = '{1'b1, 2'd0, 4'b1111, D_RR,           1'b0, 4'b0000, 1'b1, 2'd3,  2'd0};
        vecs[16] = '{1'b1, 2'd0, 4'b1111, D_RR,           1'b0, 4'b0000, 1'b1, 2'd3,  2'd0};
        vecs[17] = '{1'b1, 2'd0, 4'b1111, D_RR,           1'b1, 4'b0010, 1'b1, 2'd2,  2'd1};
        vecs[18] = '{1'b0, 2'd2, 4'b1111, D_RR,           1'b1, 4'b0100, 1'b1, 2'd1,  2'd2};
        vecs[19] = '{1'b1, 2'd0, 4'b1111, D_RR,           1'b1, 4'b0100, 1'b1, 2'd1,  2'd2};
        vecs[20] = '{1'b1, 2'd0, 4'b1111, D_RR,           1'b0, 4'b0000, 1'b1, 2'd1,  2'd2};

        // Reset state, with a channel requesting to show ready_out stays low
        reset    = 1'b1;
        mode     = 1'b0;
        selector = 2'd2;
        valid_in = 4'b0100;
        data_in  = 8'b00_11_10_01;
        ready_in = 1'b1;
        #2;
        check("rst_valid_out", 32'(valid_out), 32'd0);
        check("rst_data_out",  32'(data_out),  32'd0);
        check("rst_sel_out",   32'(sel_out),   32'd0);
        check("rst_ready_out", 32'(ready_out), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < 21; i++) begin
            mode     = vecs[i].mode;
            selector = vecs[i].sel;
            valid_in = vecs[i].vin;
            data_in  = vecs[i].din;
            ready_in = vecs[i].rdy;
            #1;
            check($sformatf("v%0d_ready_out", i), 32'(ready_out), 32'(vecs[i].exp_rdy));
            @(posedge clk);
            #1;
            check($sformatf("v%0d_valid_out", i), 32'(valid_out), 32'(vecs[i].exp_vout));
            check($sformatf("v%0d_data_out", i),  32'(data_out),  32'(vecs[i].exp_dat));
            check($sformatf("v%0d_sel_out", i),   32'(sel_out),   32'(vecs[i].exp_sel));
        end

`ifdef MUX_NTO1_STATS_EN
        check("stall_held", 32'(stall), 32'd1);
`endif

        // Reset while a word is held under backpressure: outputs clear before any edge
        reset    = 1'b1;
        ready_in = 1'b1;
        #1;
        check("midrst_valid_out", 32'(valid_out), 32'd0);
        check("midrst_data_out",  32'(data_out),  32'd0);
        check("midrst_ready_out", 32'(ready_out), 32'd0);
        @(posedge clk);
        #1;
        reset    = 1'b0;
        mode     = 1'b1;
        valid_in = 4'b1111;
        data_in  = D_RR;
        ready_in = 1'b1;
        #1;
        check("postrst_ready_out", 32'(ready_out), 32'b0001);
        @(posedge clk);
        #1;
        check("postrst_valid_out", 32'(valid_out), 32'd1);
        check("postrst_data_out",  32'(data_out),  32'd3);
        check("postrst_sel_out",   32'(sel_out),   32'd0);

`ifdef MUX_NTO1_STATS_EN
        // 300 transfers from channel 3 saturate its counter; others stay at zero
        reset = 1'b1;
        #1;
        reset    = 1'b0;
        mode     = 1'b0;
        selector = 2'd3;
        valid_in = 4'b1000;
        ready_in = 1'b1;
        repeat (300) @(posedge clk);
        #1;
        check("stat_ch3", 32'(xfer_cnt[31:24]), 32'd255);
        check("stat_ch0", 32'(xfer_cnt[7:0]),   32'd0);
        check("stat_ch1", 32'(xfer_cnt[15:8]),  32'd0);
        check("stat_ch2", 32'(xfer_cnt[23:16]), 32'd0);
        check("stall_flowing", 32'(stall), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mux_nto1_rr.md
Name: mux_nto1_rr

Overview:
- Parametrised N:1 data multiplexer with per-channel valid/ready handshake and a registered output stage.
- Two selection modes: external selector (fixed), or round-robin arbitration among valid channels.
- Generalises the two-bit 2:1 valid mux to N channels, any width, and backpressure.
- Sits between the per-lane sources and the downstream FIFO/demux stage of the datapath.

Parameters:
- DATA_W, 2, width of each data channel in bits.
- N_CH, 4, number of input channels (2..16, not required to be a power of two).
- SEL_W, $clog2(N_CH), selector/channel-id width (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- mode  input  1  0 = fixed select via selector; 1 = round-robin.
- selector  input  SEL_W  channel chosen in fixed mode.
- valid_in  input  N_CH  per-channel data valid.
- data_in  input  N_CH*DATA_W  packed data; channel k occupies bits [k*DATA_W +: DATA_W].
- ready_out  output  N_CH  one-hot pop to the granted channel (combinational).
- valid_out  output  1  output register holds valid data.
- data_out  output  DATA_W  registered data.
- sel_out  output  SEL_W  channel id of the word in data_out.
- ready_in  input  1  downstream accepts data_out this cycle.

Behaviour:
- Reset (async, immediate): valid_out=0, data_out=0, sel_out=0, rr_ptr=N_CH-1, so channel 0 has first priority. ready_out=0 while reset is high.
- load = !valid_out || ready_in. Arbitration happens only when load=1.
- Fixed mode: grant = selector if valid_in[selector]=1; otherwise no grant. There is no fallback to another channel. If selector >= N_CH, there is no grant.
- Round-robin mode: scan channels rr_ptr+1, rr_ptr+2, … modulo N_CH. Grant the first one with valid_in=1.
- Round-robin pointer: rr_ptr <= granted index on each grant. rr_ptr is unchanged with no grant, and unchanged in fixed mode.
- ready_out[g]=1 only when load=1 and the grant is g. All other bits are 0. At most one bit is high.
- Transfer from channel g occurs on the clock edge where valid_in[g] && ready_out[g]. At that edge: data_out <= channel g data, sel_out <= g, valid_out <= 1.
- load=1 with no grant: valid_out <= 0, and data_out <= 0 (deterministic zero, never X). sel_out holds its value.
- load=0 (valid_out=1, ready_in=0): all output registers hold and ready_out=0.
- Latency is one cycle from input transfer to valid_out.
- Full throughput is one word per cycle while ready_in=1.
- Simultaneous output drain and new grant in the same cycle is the normal case: no bubble.
- A mode or selector change takes effect on the next arbitration. A word already in the output register is unaffected.
- Reset asserted mid-transfer discards the held word. The upstream channel sees ready_out drop asynchronously, and no transfer is counted.
- Wrap-around: with rr_ptr=N_CH-1, the scan starts at channel 0.

Optional Feature:
- Macro: MUX_NTO1_STATS_EN.
- With the macro: adds output xfer_cnt (N_CH*8, packed per channel), an 8-bit saturating counter per channel. The counter increments on each input transfer from that channel and saturates at 255. It is reset to 0 by reset.
- With the macro: adds output stall  output 1, high when valid_out=1 and ready_in=0.
- Without the macro: neither port nor its logic exists. All other behaviour is identical.

Decomposition:
- Package mux_nto1_pkg contains:
  - the mode encodings MODE_FIXED=1'b0 and MODE_RR=1'b1;
  - a function rr_pick(valid vector, pointer) that returns grant-valid and index;
  - constant STAT_W=8.
- Sub-module rr_arbiter: combinational round-robin pick plus the rr_ptr register. Parametrised on N_CH. Reused by the future demux/crossbar.
- The top level handles fixed-mode grant, the output register and the optional stats.

Test Plan:
- Reset release, DATA_W=2, N_CH=4, mode=0, selector=2, valid_in=4'b0100, ch2 data=2'b11, ready_in=1 -> ready_out=4'b0100 on the first cycle; next cycle valid_out=1, data_out=2'b11, sel_out=2.
- Fixed mode, selector=1, valid_in=4'b1001 -> ready_out=0 every cycle; valid_out=0 and data_out=0.
- Round-robin, all four channels valid continuously, ready_in=1 -> sel_out sequence 0,1,2,3,0,1 on consecutive cycles, with one word per cycle.
- Backpressure: a word is held, ready_in=0 for 3 cycles -> data_out/sel_out are stable, ready_out=0; ready_in=1 -> the next word loads the same cycle with no bubble.
- Reset asserted while valid_out=1 and ready_in=0 -> valid_out=0 and data_out=0 immediately, before the next clock edge. After release, round-robin restarts at channel 0.
- With MUX_NTO1_STATS_EN: 300 transfers from ch3 -> xfer_cnt[ch3]=255 (saturated) and the other counters are 0. stall=1 during the backpressure window.
